// File: rtl/data_ram_bridge_pkg.sv
// Shared types for the data-RAM to 16-bit SRAM bridge: operation codes,
// FSM state encoding and the helper that picks the first half-word phase.
package data_ram_bridge_pkg;

   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;

   typedef enum logic [1:0] {
      DRB_IDLE = 2'd0,
      DRB_HI   = 2'd1,
      DRB_LO   = 2'd2,
      DRB_DONE = 2'd3
   } drb_state_t;

   // Half-word phases with no selected lane are skipped entirely
   function automatic drb_state_t first_phase(input logic [3:0] sel);
      if (sel[3:2] != 2'b00) begin
         return DRB_HI;
      end else if (sel[1:0] != 2'b00) begin
         return DRB_LO;
      end else begin
         return DRB_DONE;
      end
   endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Cycle counter for one SRAM half-word phase: counts 0..WAIT_STATES and
// flags the final cycle, where reads are captured and write data is held.
module sram_phase_counter #(
   parameter int WAIT_STATES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic tick,
   output logic last
);

   localparam int CntWidth = $clog2(WAIT_STATES + 1);

   logic [CntWidth-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (tick) begin
         count <= count + CntWidth'(1);
      end
   end

   assign last = (count == CntWidth'(WAIT_STATES));

endmodule

// File: rtl/data_ram_bridge.sv
// Responder for the CPU data-RAM port, serving 32-bit words from a 16-bit
// asynchronous SRAM in up to two half-word phases. Define DATA_RAM_ERR_EN for a sticky sel=0 error flag.
module data_ram_bridge
   import data_ram_bridge_pkg::*;
#(
   parameter int SRAM_ADDR_WIDTH = 20,
   parameter int WAIT_STATES     = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       ram_chip_enable,
   input  logic                       ram_operation,
   input  logic [31:0]                ram_addr,
   input  logic [3:0]                 ram_select_signal,
   input  logic [31:0]                ram_write_data,
   output logic [31:0]                ram_read_data,
   output logic                       stall_request,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [15:0]                sram_data_out,
   output logic                       sram_data_oe,
   input  logic [15:0]                sram_data_in,
   output logic                       sram_ce_n,
   output logic                       sram_oe_n,
   output logic                       sram_we_n,
   output logic                       sram_ub_n,
   output logic                       sram_lb_n,
   output logic                       access_error
);

   drb_state_t  state;
   drb_state_t  state_next;
   logic        in_phase;
   logic        phase_last;
   logic        is_write;
   logic        start_access;
   logic [1:0]  lane_sel;
   logic [15:0] lane_mask;
   logic        unused_addr_bits;

   assign in_phase     = (state == DRB_HI) || (state == DRB_LO);
   assign is_write     = (ram_operation == RAM_WRITE);
   assign start_access = (state == DRB_IDLE) && ram_chip_enable;
   assign lane_sel     = (state == DRB_LO) ? ram_select_signal[1:0] : ram_select_signal[3:2];
   assign lane_mask    = {{8{lane_sel[1]}}, {8{lane_sel[0]}}};
   assign stall_request = ram_chip_enable && (state != DRB_DONE);
   assign unused_addr_bits = ^{ram_addr[31:SRAM_ADDR_WIDTH+1], ram_addr[1:0]};

   sram_phase_counter #(
      .WAIT_STATES (WAIT_STATES)
   ) u_phase_counter (
      .clock (clock),
      .reset (reset),
      .load  (!in_phase || phase_last),
      .tick  (in_phase && !phase_last),
      .last  (phase_last)
   );

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= DRB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A flush (enable dropped) lets the current phase finish, then returns to IDLE without DONE
   always_comb begin
      state_next = state;
      case (state)
         DRB_IDLE: begin
            if (ram_chip_enable) begin
               state_next = first_phase(ram_select_signal);
            end
         end
         DRB_HI: begin
            if (phase_last) begin
               if (!ram_chip_enable) begin
                  state_next = DRB_IDLE;
               end else if (ram_select_signal[1:0] != 2'b00) begin
                  state_next = DRB_LO;
               end else begin
                  state_next = DRB_DONE;
               end
            end
         end
         DRB_LO: begin
            if (phase_last) begin
               state_next = ram_chip_enable ? DRB_DONE : DRB_IDLE;
            end
         end
         default: state_next = DRB_IDLE;
      endcase
   end

   // SRAM strobes; the last cycle of a write phase releases we_n to hold address and data
   always_comb begin
      sram_ce_n     = 1'b1;
      sram_oe_n     = 1'b1;
      sram_we_n     = 1'b1;
      sram_ub_n     = 1'b1;
      sram_lb_n     = 1'b1;
      sram_data_oe  = 1'b0;
      sram_data_out = 16'h0000;
      sram_addr     = '0;
      if (in_phase) begin
         sram_ce_n = 1'b0;
         sram_ub_n = ~lane_sel[1];
         sram_lb_n = ~lane_sel[0];
         sram_addr = {ram_addr[SRAM_ADDR_WIDTH:2], (state == DRB_LO)};
         if (is_write) begin
            sram_data_oe  = 1'b1;
            sram_we_n     = phase_last;
            sram_data_out = (state == DRB_LO) ? ram_write_data[15:0] : ram_write_data[31:16];
         end else begin
            sram_oe_n = 1'b0;
         end
      end
   end

   // Read data is cleared at access start so lanes never touched read back as zero
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ram_read_data <= 32'h0000_0000;
      end else if (start_access && (ram_select_signal != 4'b0000)) begin
         ram_read_data <= 32'h0000_0000;
      end else if (in_phase && phase_last && !is_write) begin
         if (state == DRB_HI) begin
            ram_read_data[31:16] <= sram_data_in & lane_mask;
         end else begin
            ram_read_data[15:0] <= sram_data_in & lane_mask;
         end
      end
   end

`ifdef DATA_RAM_ERR_EN
   // Sticky until reset: an empty byte select comes from a misaligned sub-word access
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         access_error <= 1'b0;
      end else if (start_access && (ram_select_signal == 4'b0000)) begin
         access_error <= 1'b1;
      end
   end
`else
   assign access_error = 1'b0;
`endif

endmodule
